// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises and filters the pad lines, then decodes 11-bit frames.
// It delivers make codes on gpi/gpi_we and reports framing, parity and timeout faults on frame_err.
module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int BREAK_FILTER   = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] gpi,
    output logic       gpi_we,
    output logic       frame_err,
    output logic       busy
);

    localparam int              TO_W       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_MAX     = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      FILT_MAX   = 4'(FILTER_LEN - 1);
    localparam logic [7:0]      CODE_BREAK = 8'hF0;
    localparam logic [7:0]      CODE_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Odd parity across the data byte and the received parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

    logic [1:0]      clk_sync_r;
    logic [1:0]      data_sync_r;
    logic            filt_clk_r;
    logic [3:0]      filt_cnt_r;
    logic            fall_pulse_r;
    state_t          state_r;
    state_t          state_s;
    logic [3:0]      bit_cnt_r;
    logic [7:0]      shift_r;
    logic            parity_r;
    logic            brk_r;
    logic [TO_W-1:0] to_cnt_r;
    logic [7:0]      gpi_r;
    logic            gpi_we_r;
    logic            frame_err_r;
    logic            busy_r;

    logic            data_s;
    logic            timeout_s;
    logic            eval_s;
    logic            frame_ok_s;
    logic            we_s;
    logic            err_s;
    logic            set_brk_s;
    logic            clr_brk_s;

    assign data_s = data_sync_r[1];

    // Two-flop synchronisers and the ps2_clk glitch filter with its falling-edge pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_sync_r   <= 2'b11;
            data_sync_r  <= 2'b11;
            filt_clk_r   <= 1'b1;
            filt_cnt_r   <= 4'd0;
            fall_pulse_r <= 1'b0;
        end else begin
            clk_sync_r   <= {clk_sync_r[0], ps2_clk};
            data_sync_r  <= {data_sync_r[0], ps2_data};
            fall_pulse_r <= 1'b0;
            if (clk_sync_r[1] != filt_clk_r) begin
                if (filt_cnt_r == FILT_MAX) begin
                    filt_clk_r   <= clk_sync_r[1];
                    filt_cnt_r   <= 4'd0;
                    fall_pulse_r <= filt_clk_r;
                end else begin
                    filt_cnt_r <= filt_cnt_r + 4'd1;
                end
            end else begin
                filt_cnt_r <= 4'd0;
            end
        end
    end

    // Frame state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a stalled frame is abandoned regardless of position.
    always_comb begin
        state_s = state_r;
        if (timeout_s) begin
            state_s = IDLE;
        end else if (fall_pulse_r) begin
            case (state_r)
                IDLE:    state_s = data_s ? IDLE : DATA;
                DATA:    state_s = (bit_cnt_r == 4'd7) ? PARITY : DATA;
                PARITY:  state_s = STOP;
                STOP:    state_s = IDLE;
                default: state_s = IDLE;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Frame evaluation and break/extended-prefix filtering decisions.
    always_comb begin
        timeout_s  = (state_r != IDLE) && (to_cnt_r == TO_MAX) && !fall_pulse_r;
        eval_s     = fall_pulse_r && (state_r == STOP);
        frame_ok_s = data_s && odd_parity_ok(shift_r, parity_r);
        we_s       = 1'b0;
        set_brk_s  = 1'b0;
        clr_brk_s  = 1'b0;
        err_s      = 1'b0;
        if (timeout_s) begin
            err_s     = 1'b1;
            clr_brk_s = 1'b1;
        end else if (eval_s) begin
            if (!frame_ok_s) begin
                err_s     = 1'b1;
                clr_brk_s = 1'b1;
            end else if (BREAK_FILTER == 0) begin
                we_s = 1'b1;
            end else if (shift_r == CODE_BREAK) begin
                set_brk_s = 1'b1;
            end else if (shift_r == CODE_EXT) begin
                we_s = 1'b0;
            end else if (brk_r) begin
                clr_brk_s = 1'b1;
            end else begin
                we_s = 1'b1;
            end
        end else begin
            err_s = 1'b0;
        end
    end

    // Shift register, bit counter, parity capture, break flag and timeout counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bit_cnt_r <= 4'd0;
            shift_r   <= 8'h00;
            parity_r  <= 1'b0;
            brk_r     <= 1'b0;
            to_cnt_r  <= '0;
        end else begin
            if (fall_pulse_r && !timeout_s) begin
                case (state_r)
                    IDLE: bit_cnt_r <= 4'd0;
                    DATA: begin
                        shift_r   <= {data_s, shift_r[7:1]};
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                    end
                    PARITY:  parity_r <= data_s;
                    STOP:    bit_cnt_r <= 4'd0;
                    default: bit_cnt_r <= 4'd0;
                endcase
            end
            if (set_brk_s) begin
                brk_r <= 1'b1;
            end else if (clr_brk_s) begin
                brk_r <= 1'b0;
            end
            if ((state_r == IDLE) || fall_pulse_r) begin
                to_cnt_r <= '0;
            end else if (to_cnt_r != TO_MAX) begin
                to_cnt_r <= to_cnt_r + 1'b1;
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gpi_r       <= 8'h00;
            gpi_we_r    <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            if (we_s) begin
                gpi_r <= shift_r;
            end
            gpi_we_r    <= we_s;
            frame_err_r <= err_s;
            busy_r      <= (state_s != IDLE);
        end
    end

    assign gpi       = gpi_r;
    assign gpi_we    = gpi_we_r;
    assign frame_err = frame_err_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench: one instance with break filtering, one delivering every byte, sharing the PS/2 lines.
module tb_ps2_keyboard_rx;

    localparam int HALF = 20;
    localparam int TO   = 200;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] gpi, gpi0;
    logic       gpi_we, gpi_we0, frame_err, frame_err0, busy, busy0;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int we_cnt = 0, err_cnt = 0, both_cnt = 0, err0_cnt = 0;
    int we_cyc = 0, err_cyc = 0, last_fall_cyc = 0;
    logic [7:0] log0[$];

    ps2_keyboard_rx #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TO), .BREAK_FILTER(1)) dut (
        .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .gpi(gpi), .gpi_we(gpi_we), .frame_err(frame_err), .busy(busy)
    );

    ps2_keyboard_rx #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TO), .BREAK_FILTER(0)) dut0 (
        .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .gpi(gpi0), .gpi_we(gpi_we0), .frame_err(frame_err0), .busy(busy0)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (gpi_we) begin
            we_cnt = we_cnt + 1;
            we_cyc = cyc;
        end
        if (frame_err) begin
            err_cnt = err_cnt + 1;
            err_cyc = cyc;
        end
        if (gpi_we && frame_err) both_cnt = both_cnt + 1;
        if (gpi_we0) log0.push_back(gpi0);
        if (frame_err0) err0_cnt = err0_cnt + 1;
    end

    function automatic logic [10:0] mk(input logic [7:0] b, input logic flip);
        return {1'b1, (~^b) ^ flip, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_bit);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            if (i == glitch_bit) begin
                repeat (HALF / 2) @(negedge clock);
                ps2_clk = 1'b0;
                repeat (2) @(negedge clock);
                ps2_clk = 1'b1;
                repeat (HALF / 2 - 2) @(negedge clock);
            end else begin
                repeat (HALF) @(negedge clock);
            end
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            repeat (HALF) @(negedge clock);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip, input int glitch_bit);
        send_bits(mk(b, flip), 11, glitch_bit);
        ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge clock);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        compared++; if (gpi !== 8'h00) begin mismatched++; $display("FAIL reset_gpi: got %h want 00", gpi); end
        compared++; if (gpi_we !== 1'b0 || frame_err !== 1'b0) begin mismatched++; $display("FAIL reset_strobes: we=%b err=%b want 0/0", gpi_we, frame_err); end
        compared++; if (busy !== 1'b0 || busy0 !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b/%b want 0/0", busy, busy0); end
    endtask

    task automatic test_single();
        int w = we_cnt; int e = err_cnt; int lat;
        send_frame(8'h1C, 1'b0, -1);
        lat = we_cyc - last_fall_cyc;
        compared++; if (gpi !== 8'h1C) begin mismatched++; $display("FAIL single_gpi: got %h want 1c", gpi); end
        compared++; if (we_cnt - w !== 1) begin mismatched++; $display("FAIL single_we_count: got %0d want 1", we_cnt - w); end
        compared++; if (lat < 5 || lat > 10) begin mismatched++; $display("FAIL single_latency: got %0d want 5..10 cycles after raw edge", lat); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL single_busy: got %b want 0", busy); end
        compared++; if (err_cnt - e !== 0) begin mismatched++; $display("FAIL single_err: got %0d want 0", err_cnt - e); end
    endtask

    task automatic test_break();
        int w = we_cnt; int b0 = log0.size();
        send_frame(8'hF0, 1'b0, -1);
        send_frame(8'h1C, 1'b0, -1);
        compared++; if (we_cnt - w !== 0) begin mismatched++; $display("FAIL break_suppressed: got %0d strobes want 0", we_cnt - w); end
        compared++; if (gpi !== 8'h1C) begin mismatched++; $display("FAIL break_gpi_hold: got %h want 1c", gpi); end
        send_frame(8'h32, 1'b0, -1);
        compared++; if (gpi !== 8'h32 || we_cnt - w !== 1) begin mismatched++; $display("FAIL break_make: gpi=%h strobes=%0d want 32/1", gpi, we_cnt - w); end
        compared++; if (log0.size() - b0 !== 3) begin mismatched++; $display("FAIL nofilter_count: got %0d want 3", log0.size() - b0); end
        if (log0.size() - b0 >= 3) begin
            compared++; if (log0[b0] !== 8'hF0 || log0[b0+1] !== 8'h1C || log0[b0+2] !== 8'h32) begin
                mismatched++; $display("FAIL nofilter_codes: got %h %h %h want f0 1c 32", log0[b0], log0[b0+1], log0[b0+2]);
            end
        end
        w = we_cnt;
        send_frame(8'hE0, 1'b0, -1);
        send_frame(8'h75, 1'b0, -1);
        compared++; if (gpi !== 8'h75 || we_cnt - w !== 1) begin mismatched++; $display("FAIL ext_prefix: gpi=%h strobes=%0d want 75/1", gpi, we_cnt - w); end
    endtask

    task automatic test_parity();
        int w = we_cnt; int e = err_cnt;
        send_frame(8'h1C, 1'b1, -1);
        compared++; if (err_cnt - e !== 1 || we_cnt - w !== 0) begin mismatched++; $display("FAIL parity_err: errs=%0d strobes=%0d want 1/0", err_cnt - e, we_cnt - w); end
        compared++; if (gpi !== 8'h75) begin mismatched++; $display("FAIL parity_gpi_hold: got %h want 75", gpi); end
        send_frame(8'h2A, 1'b0, -1);
        compared++; if (gpi !== 8'h2A || err_cnt - e !== 1) begin mismatched++; $display("FAIL parity_recover: gpi=%h errs=%0d want 2a/1", gpi, err_cnt - e); end
    endtask

    task automatic test_timeout();
        int e = err_cnt; int f; int lat;
        send_bits(mk(8'h45, 1'b0), 4, -1);
        ps2_data = 1'b1;
        f = last_fall_cyc;
        repeat (TO - 30) @(negedge clock);
        compared++; if (err_cnt - e !== 0 || busy !== 1'b1) begin mismatched++; $display("FAIL timeout_early: errs=%0d busy=%b want 0/1", err_cnt - e, busy); end
        repeat (40) @(negedge clock);
        lat = err_cyc - f;
        compared++; if (err_cnt - e !== 1 || busy !== 1'b0) begin mismatched++; $display("FAIL timeout_fire: errs=%0d busy=%b want 1/0", err_cnt - e, busy); end
        compared++; if (lat < TO - 5 || lat > TO + 15) begin mismatched++; $display("FAIL timeout_latency: got %0d want near %0d", lat, TO); end
        send_frame(8'h45, 1'b0, -1);
        compared++; if (gpi !== 8'h45) begin mismatched++; $display("FAIL timeout_recover: got %h want 45", gpi); end
    endtask

    task automatic test_glitch();
        int e = err_cnt;
        ps2_data = 1'b0;
        repeat (4) @(negedge clock);
        ps2_clk = 1'b0;
        repeat (2) @(negedge clock);
        ps2_clk = 1'b1;
        repeat (12) @(negedge clock);
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL glitch_idle: busy=%b want 0", busy); end
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clock);
        send_frame(8'h5A, 1'b0, 4);
        compared++; if (gpi !== 8'h5A || err_cnt - e !== 0) begin mismatched++; $display("FAIL glitch_frame: gpi=%h errs=%0d want 5a/0", gpi, err_cnt - e); end
    endtask

    task automatic test_back_to_back();
        int w = we_cnt;
        send_bits(mk(8'h11, 1'b0), 11, -1);
        send_bits(mk(8'h22, 1'b0), 11, -1);
        ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge clock);
        compared++; if (gpi !== 8'h22 || we_cnt - w !== 2) begin mismatched++; $display("FAIL back_to_back: gpi=%h strobes=%0d want 22/2", gpi, we_cnt - w); end
    endtask

    task automatic test_reset_mid_frame();
        int w; int e;
        send_bits(mk(8'h1C, 1'b0), 6, -1);
        @(negedge clock);
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL midreset_busy_before: got %b want 1", busy); end
        #2 reset = 1'b0;
        #1;
        compared++; if (gpi !== 8'h00 || gpi0 !== 8'h00) begin mismatched++; $display("FAIL midreset_gpi: got %h/%h want 00/00", gpi, gpi0); end
        compared++; if (busy !== 1'b0 || busy0 !== 1'b0 || gpi_we !== 1'b0 || frame_err !== 1'b0) begin
            mismatched++; $display("FAIL midreset_ctl: busy=%b/%b we=%b err=%b want 0", busy, busy0, gpi_we, frame_err);
        end
        ps2_data = 1'b1;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        repeat (10) @(negedge clock);
        w = we_cnt; e = err_cnt;
        send_frame(8'h1C, 1'b0, -1);
        compared++; if (gpi !== 8'h1C || we_cnt - w !== 1 || err_cnt - e !== 0) begin
            mismatched++; $display("FAIL midreset_recover: gpi=%h strobes=%0d errs=%0d want 1c/1/0", gpi, we_cnt - w, err_cnt - e);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_break();
        test_parity();
        test_timeout();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        compared++; if (both_cnt !== 0) begin mismatched++; $display("FAIL we_err_overlap: got %0d want 0", both_cnt); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
